// File: rtl/systolic_pkg.sv
// Shared types and default geometry for the systolic array operand feeder.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      FLUSH,
      DONE
   } fsm_state_t;

   localparam int DATA_W_DEF = 8;
   localparam int ROWS_DEF   = 4;
   localparam int COLS_DEF   = 4;
   localparam int K_MAX_DEF  = 16;

endpackage

// File: rtl/skew_delay_line.sv
// Synchronous-reset shift register used to skew one operand lane; DEPTH=0 is a plain wire.
module skew_delay_line #(
   parameter int W     = 8,
   parameter int DEPTH = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ok;
         assign unused_ok = ^{clk, rst};
         assign q = d;
      end else begin : g_shift
         logic [W-1:0] stages [DEPTH];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < DEPTH; k++) begin
                  stages[k] <= '0;
               end
            end else begin
               stages[0] <= d;
               for (int k = 1; k < DEPTH; k++) begin
                  stages[k] <= stages[k-1];
               end
            end
         end

         assign q = stages[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the wavefront systolic array: accepts K-slices, applies the
// diagonal skew per lane, and sequences one tile followed by a skew flush.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ROWS   = ROWS_DEF,
   parameter int COLS   = COLS_DEF,
   parameter int K_MAX  = K_MAX_DEF,
   parameter int KW     = $clog2(K_MAX + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [KW-1:0]          k_len,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [ROWS*DATA_W-1:0] s_a,
   input  logic [COLS*DATA_W-1:0] s_b,
   output logic [ROWS*DATA_W-1:0] a_in_bus,
   output logic [COLS*DATA_W-1:0] b_in_bus,
   output logic                   valid_in,
   output logic                   busy,
   output logic                   done
);

   // Deepest lane delay; FLUSH runs one extra cycle so that lane's output
   // register has presented the last slice before done is raised.
   localparam int F          = ((ROWS > COLS) ? ROWS : COLS) - 1;
   localparam int FW         = $clog2(F + 2);
   localparam int FLUSH_LAST = F;

   fsm_state_t state, next_state;

   logic [KW-1:0]          k_lat;
   logic [KW-1:0]          slice_cnt;
   logic [KW-1:0]          k_clamped;
   logic [FW-1:0]          flush_cnt;
   logic                   accept;
   logic [ROWS*DATA_W-1:0] a_head, a_dly;
   logic [COLS*DATA_W-1:0] b_head, b_dly;

   assign accept    = s_valid && s_ready;
   assign k_clamped = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

   // Bubbles and idle cycles push zeros down every lane so no stale data leaks out.
   assign a_head = accept ? s_a : '0;
   assign b_head = accept ? s_b : '0;

   generate
      for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
         skew_delay_line #(.W(DATA_W), .DEPTH(i)) u_dly (
            .clk (clk),
            .rst (rst),
            .d   (a_head[(i+1)*DATA_W-1 -: DATA_W]),
            .q   (a_dly[(i+1)*DATA_W-1 -: DATA_W])
         );
      end
      for (genvar j = 0; j < COLS; j++) begin : g_b_lane
         skew_delay_line #(.W(DATA_W), .DEPTH(j)) u_dly (
            .clk (clk),
            .rst (rst),
            .d   (b_head[(j+1)*DATA_W-1 -: DATA_W]),
            .q   (b_dly[(j+1)*DATA_W-1 -: DATA_W])
         );
      end
   endgenerate

   always_comb begin
      next_state = state;
      s_ready    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (k_len == '0) ? DONE : FEED;
            end
         end
         FEED: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (accept && ((slice_cnt + KW'(1)) == k_lat)) begin
               next_state = FLUSH;
            end
         end
         FLUSH: begin
            busy = 1'b1;
            if (flush_cnt == FW'(FLUSH_LAST)) begin
               next_state = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k_lat     <= '0;
         slice_cnt <= '0;
         flush_cnt <= '0;
         a_in_bus  <= '0;
         b_in_bus  <= '0;
         valid_in  <= 1'b0;
      end else begin
         state    <= next_state;
         a_in_bus <= a_dly;
         b_in_bus <= b_dly;
         valid_in <= accept;
         if (state == IDLE && start) begin
            k_lat     <= k_clamped;
            slice_cnt <= '0;
         end else if (accept) begin
            slice_cnt <= slice_cnt + KW'(1);
         end
         flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with hand-computed per-cycle bus values.
module tb_systolic_feeder;

   localparam int KW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [KW-1:0] k_len;
   logic          s_valid;
   logic          s_ready;
   logic [31:0]   s_a, s_b;
   logic [31:0]   a_in_bus, b_in_bus;
   logic          valid_in, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   systolic_feeder #(.DATA_W(8), .ROWS(4), .COLS(4), .K_MAX(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .k_len    (k_len),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_a      (s_a),
      .s_b      (s_b),
      .a_in_bus (a_in_bus),
      .b_in_bus (b_in_bus),
      .valid_in (valid_in),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic [KW-1:0] kl, input logic sv,
                                input logic [31:0] a, input logic [31:0] b);
      start   = st;
      k_len   = kl;
      s_valid = sv;
      s_a     = a;
      s_b     = b;
   endtask

   task automatic checkSignal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic v, input logic r, input logic bz, input logic d);
      checkSignal({tag, ".a_in_bus"}, a_in_bus, a);
      checkSignal({tag, ".b_in_bus"}, b_in_bus, b);
      checkSignal({tag, ".valid_in"}, 32'(valid_in), 32'(v));
      checkSignal({tag, ".s_ready"}, 32'(s_ready), 32'(r));
      checkSignal({tag, ".busy"}, 32'(busy), 32'(bz));
      checkSignal({tag, ".done"}, 32'(done), 32'(d));
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      tick();
      checkOutput("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();

      $display("[TB] single slice");
      checkOutput("t1.idle", 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0);
      tick();
      checkOutput("t1.feed", 0, 0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 32'h04030201, 32'h08070605);
      tick();
      checkOutput("t1.n0", 32'h00000001, 32'h00000005, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      checkOutput("t1.n1", 32'h00000200, 32'h00000600, 0, 0, 1, 0);
      tick();
      checkOutput("t1.n2", 32'h00030000, 32'h00070000, 0, 0, 1, 0);
      tick();
      checkOutput("t1.n3", 32'h04000000, 32'h08000000, 0, 0, 1, 0);
      tick();
      checkOutput("t1.done", 0, 0, 0, 0, 0, 1);
      tick();
      checkOutput("t1.idle2", 0, 0, 0, 0, 0, 0);

      $display("[TB] full tile with ignored start and flush-time s_valid");
      applyStimulus(1, 4, 0, 0, 0);
      tick();
      checkOutput("t2.feed0", 0, 0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 32'h03020100, 32'h03020100);
      tick();
      checkOutput("t2.n0", 0, 0, 1, 1, 1, 0);
      applyStimulus(1, 2, 1, 32'h0D0C0B0A, 32'h0D0C0B0A);
      tick();
      checkOutput("t2.n1", 32'h0000010A, 32'h0000010A, 1, 1, 1, 0);
      applyStimulus(0, 0, 1, 32'h17161514, 32'h17161514);
      tick();
      checkOutput("t2.n2", 32'h00020B14, 32'h00020B14, 1, 1, 1, 0);
      applyStimulus(0, 0, 1, 32'h21201F1E, 32'h21201F1E);
      tick();
      checkOutput("t2.n3", 32'h030C151E, 32'h030C151E, 1, 0, 1, 0);
      applyStimulus(0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tick();
      checkOutput("t2.n4", 32'h0D161F00, 32'h0D161F00, 0, 0, 1, 0);
      tick();
      checkOutput("t2.n5", 32'h17200000, 32'h17200000, 0, 0, 1, 0);
      tick();
      checkOutput("t2.n6", 32'h21000000, 32'h21000000, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      checkOutput("t2.done", 0, 0, 0, 0, 0, 1);
      tick();
      checkOutput("t2.idle", 0, 0, 0, 0, 0, 0);

      $display("[TB] bubbles");
      applyStimulus(1, 3, 0, 0, 0);
      tick();
      checkOutput("t3.feed0", 0, 0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 32'h01010101, 32'h81818181);
      tick();
      checkOutput("t3.n0", 32'h00000001, 32'h00000081, 1, 1, 1, 0);
      applyStimulus(0, 0, 0, 32'hEEEEEEEE, 32'hEEEEEEEE);
      tick();
      checkOutput("t3.n1", 32'h00000100, 32'h00008100, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 32'h02020202, 32'h82828282);
      tick();
      checkOutput("t3.n2", 32'h00010002, 32'h00810082, 1, 1, 1, 0);
      applyStimulus(0, 0, 0, 32'hEEEEEEEE, 32'hEEEEEEEE);
      tick();
      checkOutput("t3.n3", 32'h01000200, 32'h81008200, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 32'h03030303, 32'h83838383);
      tick();
      checkOutput("t3.n4", 32'h00020003, 32'h00820083, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      checkOutput("t3.n5", 32'h02000300, 32'h82008300, 0, 0, 1, 0);
      tick();
      checkOutput("t3.n6", 32'h00030000, 32'h00830000, 0, 0, 1, 0);
      tick();
      checkOutput("t3.n7", 32'h03000000, 32'h83000000, 0, 0, 1, 0);
      tick();
      checkOutput("t3.done", 0, 0, 0, 0, 0, 1);
      tick();

      $display("[TB] s_valid in IDLE and zero-length tile");
      applyStimulus(0, 0, 1, 32'h12345678, 32'h9ABCDEF0);
      tick();
      checkOutput("t4.idle_valid", 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      tick();
      checkOutput("t4.done", 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      checkOutput("t4.idle", 0, 0, 0, 0, 0, 0);

      $display("[TB] reset during FLUSH");
      applyStimulus(1, 1, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 1, 32'h04030201, 32'h08070605);
      tick();
      checkOutput("t5.n0", 32'h00000001, 32'h00000005, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      checkOutput("t5.flush", 32'h00000200, 32'h00000600, 0, 0, 1, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t5.after_rst", 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("t5.quiet1", 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("t5.quiet2", 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("t5.quiet3", 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0);
      tick();
      checkOutput("t5.feed", 0, 0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 32'h44332211, 32'h88776655);
      tick();
      checkOutput("t5.r0", 32'h00000011, 32'h00000055, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      checkOutput("t5.r1", 32'h00002200, 32'h00006600, 0, 0, 1, 0);
      tick();
      checkOutput("t5.r2", 32'h00330000, 32'h00770000, 0, 0, 1, 0);
      tick();
      checkOutput("t5.r3", 32'h44000000, 32'h88000000, 0, 0, 1, 0);
      tick();
      checkOutput("t5.done", 0, 0, 0, 0, 0, 1);
      tick();

      $display("[TB] k_len clamp");
      applyStimulus(1, 20, 0, 0, 0);
      tick();
      for (int i = 0; i < 16; i++) begin
         checkSignal("t6.ready", 32'(s_ready), 32'd1);
         applyStimulus(0, 0, 1, 32'h01010101, 32'h01010101);
         tick();
      end
      checkSignal("t6.ready_low", 32'(s_ready), 32'd0);
      checkSignal("t6.busy", 32'(busy), 32'd1);
      checkSignal("t6.last_valid", 32'(valid_in), 32'd1);
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      checkSignal("t6.no_done_early", 32'(done), 32'd0);
      tick();
      tick();
      tick();
      checkSignal("t6.done", 32'(done), 32'd1);
      tick();
      checkOutput("t6.idle", 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
